// File: rtl/regfile_param_if.sv
// Register-file bus: one write port, NUM_RD packed combinational read ports,
// plus the ready / dropped-write status returned to the pipeline.
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     ready;
  logic                     wr_drop;

  modport master (
    output we, waddr, wdata, raddr,
    input  rdata, ready, wr_drop
  );

  modport slave (
    input  we, waddr, wdata, raddr,
    output rdata, ready, wr_drop
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised decode-stage register file: rising-edge write, optional same-cycle
// bypass and hard-wired zero entry, cleared by a one-entry-per-cycle sweep after reset.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  regfile_param_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                   state, state_nxt;
  logic [ADDR_W-1:0]        ptr, ptr_nxt;
  logic                     wr_drop_q;
  logic                     ready_i;
  logic                     acc;
  logic                     zero_hit;
  logic                     sweep_we;
  logic [DATA_W-1:0]        mem [DEPTH];
  logic [NUM_RD*DATA_W-1:0] rdata_c;
  logic [ADDR_W-1:0]        ra;
  logic [DATA_W-1:0]        rd;

  assign ready_i  = (state == RUN);
  assign zero_hit = (ZERO_REG != 0) && (bus.waddr == '0);
  // A write arriving with rst is never taken, even though state is still RUN.
  assign acc      = bus.we & ready_i & ~rst & ~zero_hit;
  assign sweep_we = (state == CLEAR) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      ptr       <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      wr_drop_q <= bus.we & ~acc;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      CLEAR: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == ADDR_W'(DEPTH - 1)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  // Array storage carries no reset; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[ptr] <= '0;
    end else if (acc) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  always_comb begin
    rdata_c = '0;
    ra      = '0;
    rd      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = bus.raddr[k*ADDR_W +: ADDR_W];
      if (state == CLEAR) begin
        rd = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
      end else if ((BYPASS != 0) && acc && (bus.waddr == ra)) begin
        rd = bus.wdata;
      end else begin
        rd = mem[ra];
      end
      rdata_c[k*DATA_W +: DATA_W] = rd;
    end
  end

  assign bus.rdata   = rdata_c;
  assign bus.ready   = ready_i;
  assign bus.wr_drop = wr_drop_q;
endmodule
